// File: rtl/pcm_clk_gen.sv
// PCM/I2S clock generator: divides CLK (qualified by EN_CLK) into a bit clock
// with edge strobes, plus a word-select clock and bit index within each slot.
module pcm_clk_gen #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 50,
    parameter int FRAME_BITS  = 32,
    parameter int SLOT_W      = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN_CLK,
    input  logic              DIV_LOAD,
    input  logic [CNT_W-1:0]  DIV_IN,
    output logic              BCLK,
    output logic              BCLK_RISE,
    output logic              BCLK_FALL,
    output logic              LRCLK,
    output logic [SLOT_W-1:0] BIT_IDX,
    output logic              FRAME_START
);

    localparam logic [CNT_W-1:0]  DIV_RST  = (DIV_DEFAULT < 1) ? CNT_W'(1) : CNT_W'(DIV_DEFAULT);
    localparam logic [SLOT_W-1:0] LAST_BIT = SLOT_W'(FRAME_BITS - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_r;
    logic [CNT_W-1:0] pend_val;
    logic             pend_valid;

    logic             toggle;
    logic             fall;
    logic             last_bit;
    logic [CNT_W-1:0] div_in_eff;

    always_comb begin
        toggle     = EN_CLK && (count == div_r);
        fall       = toggle && BCLK;
        last_bit   = (BIT_IDX == LAST_BIT);
        div_in_eff = (DIV_IN == '0) ? CNT_W'(1) : DIV_IN;
    end

    // Divider counter and bit clock; a toggle cycle is also the only point
    // where the divisor may change, so every half-period is whole.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count     <= CNT_W'(1);
            BCLK      <= 1'b0;
            BCLK_RISE <= 1'b0;
            BCLK_FALL <= 1'b0;
        end else begin
            BCLK_RISE <= toggle && !BCLK;
            BCLK_FALL <= fall;
            if (toggle) begin
                count <= CNT_W'(1);
                BCLK  <= !BCLK;
            end else if (EN_CLK) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Divisor update: a load landing on a toggle cycle bypasses the pending
    // register; otherwise the last load waits for the next toggle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_r      <= DIV_RST;
            pend_val   <= '0;
            pend_valid <= 1'b0;
        end else if (DIV_LOAD) begin
            if (toggle) begin
                div_r      <= div_in_eff;
                pend_valid <= 1'b0;
            end else begin
                pend_val   <= div_in_eff;
                pend_valid <= 1'b1;
            end
        end else if (toggle && pend_valid) begin
            div_r      <= pend_val;
            pend_valid <= 1'b0;
        end
    end

    // Slot tracking advances on BCLK falling edges.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LRCLK       <= 1'b0;
            BIT_IDX     <= '0;
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= fall && last_bit && LRCLK;
            if (fall) begin
                if (last_bit) begin
                    BIT_IDX <= '0;
                    LRCLK   <= !LRCLK;
                end else begin
                    BIT_IDX <= BIT_IDX + SLOT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/pcm_clk_gen.md
PCM_CLK_GEN -- requirements
Module: pcm_clk_gen

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the divider counter and DIV_IN width.
REQ-002 The module SHALL have parameter DIV_DEFAULT, default 50, giving the BCLK half-period in enabled CLK cycles after reset.
REQ-003 The module SHALL have parameter FRAME_BITS, default 32, giving the BCLK periods per LRCLK half (channel slot); legal range 2..2^SLOT_W.
REQ-004 The module SHALL have parameter SLOT_W, default 6, giving the BIT_IDX width.
REQ-005 Port CLK: input, 1 bit, system clock; all logic is on the rising edge.
REQ-006 Port RESET: input, 1 bit, reset, synchronous, active-high.
REQ-007 Port EN_CLK: input, 1 bit, clock enable; counting advances only when high.
REQ-008 Port DIV_LOAD: input, 1 bit, single-cycle request to load DIV_IN as the new half-period.
REQ-009 Port DIV_IN: input, CNT_W bits, requested half-period in enabled cycles.
REQ-010 Port BCLK: output, 1 bit, registered bit clock.
REQ-011 Port BCLK_RISE: output, 1 bit, one-cycle strobe in the cycle BCLK changes 0->1.
REQ-012 Port BCLK_FALL: output, 1 bit, one-cycle strobe in the cycle BCLK changes 1->0.
REQ-013 Port LRCLK: output, 1 bit, registered word/channel select; 0 = left slot, 1 = right slot.
REQ-014 Port BIT_IDX: output, SLOT_W bits, bit position within the current slot, 0..FRAME_BITS-1.
REQ-015 Port FRAME_START: output, 1 bit, one-cycle strobe in the cycle LRCLK changes 1->0.

Function
REQ-016 Internal COUNT (CNT_W bits) SHALL run from 1 to DIV_R (the active divisor); on an enabled cycle with COUNT==DIV_R, COUNT SHALL become 1 and BCLK SHALL toggle; otherwise COUNT SHALL increment by 1.
REQ-017 Each BCLK half-period SHALL be exactly DIV_R enabled cycles, including the first half-period after reset.
REQ-018 With EN_CLK low, COUNT, BCLK, LRCLK and BIT_IDX SHALL hold, and all strobes SHALL be 0.
REQ-019 A DIV_IN value of 0 SHALL be treated as 1, giving BCLK = CLK/2 when EN_CLK is held high.
REQ-020 DIV_LOAD SHALL capture DIV_IN into a pending register regardless of EN_CLK; when DIV_LOAD is repeated, the last value wins.
REQ-021 A pending value SHALL transfer to DIV_R only on a BCLK toggle cycle, so BCLK has no shortened or glitched half-period.
REQ-022 If DIV_LOAD coincides with a toggle cycle, DIV_IN SHALL become DIV_R for the half-period that starts on the next cycle, and the pending register SHALL clear.
REQ-023 BCLK_RISE and BCLK_FALL SHALL be registered, and SHALL be asserted in the same cycle the BCLK output shows the new level.
REQ-024 On each BCLK 1->0 transition, BIT_IDX SHALL increment; at FRAME_BITS-1 it SHALL wrap to 0 and LRCLK SHALL toggle in the same cycle.
REQ-025 FRAME_START SHALL be asserted in the cycle LRCLK changes 1->0, coincident with BCLK_FALL and BIT_IDX==0.
REQ-026 One full LRCLK period SHALL equal 2*FRAME_BITS BCLK periods, i.e. 4*FRAME_BITS*DIV_R enabled cycles.

Reset
REQ-027 While RESET is high, the module SHALL set COUNT=1, DIV_R=DIV_DEFAULT, pending cleared, BCLK=0, LRCLK=0, BIT_IDX=0, and BCLK_RISE=BCLK_FALL=FRAME_START=0; RESET overrides EN_CLK and DIV_LOAD.
REQ-028 A RESET asserted mid-half-period or mid-slot SHALL abort immediately, with no strobe issued in that cycle.

Verification
REQ-029 Defaults, EN_CLK=1 constant -> BCLK rises at enabled cycle 50 after reset release and falls at cycle 100; period 100 CLK.
REQ-030 EN_CLK toggling 1-of-2 cycles -> BCLK half-period = 100 CLK cycles; outputs and strobes frozen in disabled cycles.
REQ-031 DIV_LOAD with DIV_IN=10 at COUNT=20 -> current half-period completes at 50, and the following half-periods are 10; DIV_IN=0 -> half-period 1.
REQ-032 DIV_LOAD coincident with a toggle cycle, DIV_IN=7 -> the very next half-period is 7 cycles.
REQ-033 FRAME_BITS=4, DIV=1 -> LRCLK toggles every 4 BCLK falls (period 16 CLK); FRAME_START once per 16 CLK with BIT_IDX=0.
REQ-034 RESET pulsed at LRCLK=1, BIT_IDX=3 -> all outputs return to reset values next cycle; restart timing identical to REQ-029.
